// File: rtl/pipe_gap_scheduler_if.sv
// Grant-side bundle between the pipe spawners and the gap scheduler.
// The scheduler uses the master modport; the spawners use the slave modport.
interface pipe_gap_scheduler_if #(
  parameter int unsigned NUM_REQ = 4
);
  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] req;
  logic               gnt_valid;
  logic               gnt_ready;
  logic [ID_W-1:0]    gnt_id;
  logic [8:0]         gnt_gap;

  modport master (
    input  req,
    input  gnt_ready,
    output gnt_valid,
    output gnt_id,
    output gnt_gap
  );

  modport slave (
    output req,
    output gnt_ready,
    input  gnt_valid,
    input  gnt_id,
    input  gnt_gap
  );
endinterface

// File: rtl/pipe_gap_scheduler.sv
// Round-robin sharing of the game's 8-bit LFSR between pipe-spawn slots.
// It spins the generator for a full refresh, then offers a legal gap row to the winner.
module pipe_gap_scheduler #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned RNG_SETTLE    = 9,
  parameter int unsigned GAP_MIN       = 40,
  parameter int unsigned GAP_SPAN_LOG2 = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 rng_enable,
  input  logic [7:0]           rng_value,
  pipe_gap_scheduler_if.master bus
);

  localparam int unsigned ID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned IDX_W     = ID_W + 1;
  localparam int unsigned CNT_W     = (RNG_SETTLE > 1) ? $clog2(RNG_SETTLE) : 1;
  localparam int unsigned GAP_W     = 9;
  localparam int unsigned SPAN      = 1 << GAP_SPAN_LOG2;
  localparam logic [7:0]  SPAN_MASK = 8'(SPAN - 1);
  localparam logic [CNT_W-1:0] SPIN_LAST = CNT_W'(RNG_SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SPIN    = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_OFFER   = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   spin_cnt;
  logic [ID_W-1:0]    ptr;
  logic [GAP_W-1:0]   last_gap;
  logic               retry;

  logic [ID_W-1:0]    winner;
  logic               found;
  logic [IDX_W-1:0]   idx;
  logic [GAP_W-1:0]   cand;
  logic [ID_W-1:0]    next_ptr;

  // Round-robin pick: first set request bit at or above ptr, wrapping.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'(ptr) + IDX_W'(i);
      if (idx >= IDX_W'(NUM_REQ)) begin
        idx = idx - IDX_W'(NUM_REQ);
      end
      if (!found && bus.req[idx[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = idx[ID_W-1:0];
      end
    end
  end

  assign cand     = GAP_W'(GAP_MIN) + {1'b0, rng_value & SPAN_MASK};
  assign next_ptr = (bus.gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : bus.gnt_id + ID_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      spin_cnt      <= '0;
      ptr           <= '0;
      last_gap      <= '0;
      retry         <= 1'b0;
      rng_enable    <= 1'b0;
      bus.gnt_valid <= 1'b0;
      bus.gnt_id    <= '0;
      bus.gnt_gap   <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (found) begin
            bus.gnt_id <= winner;
            spin_cnt   <= '0;
            rng_enable <= 1'b1;
            state      <= ST_SPIN;
          end
        end
        ST_SPIN: begin
          if (spin_cnt == SPIN_LAST) begin
            rng_enable <= 1'b0;
            state      <= ST_CAPTURE;
          end else begin
            spin_cnt <= spin_cnt + CNT_W'(1);
          end
        end
        ST_CAPTURE: begin
          // One re-spin avoids repeating the previous gap; a second duplicate is accepted.
          if ((cand == last_gap) && !retry) begin
            retry      <= 1'b1;
            spin_cnt   <= '0;
            rng_enable <= 1'b1;
            state      <= ST_SPIN;
          end else begin
            bus.gnt_gap   <= cand;
            bus.gnt_valid <= 1'b1;
            state         <= ST_OFFER;
          end
        end
        ST_OFFER: begin
          if (bus.gnt_ready) begin
            last_gap      <= bus.gnt_gap;
            ptr           <= next_ptr;
            retry         <= 1'b0;
            bus.gnt_valid <= 1'b0;
            state         <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipe_gap_scheduler.md
# pipe_gap_scheduler

Shares the game's single 8-bit LFSR random generator between up to `NUM_REQ` pipe-spawn slots. A requesting slot is selected round-robin. The block clocks the generator for one full refresh period and maps the refreshed value into a legal vertical gap position. It then hands that gap back to the slot through a valid/ready handshake. It sits between the pipe spawners and the random generator, and it is the only driver of the generator's `enable`.

## Interface
- `NUM_REQ`, 4: number of requesting pipe slots (2..8).
- `RNG_SETTLE`, 9: enabled clocks the generator needs to publish a fresh value.
- `GAP_MIN`, 40: smallest legal gap top row.
- `GAP_SPAN_LOG2`, 7: gap range is `GAP_MIN .. GAP_MIN + 2^GAP_SPAN_LOG2 - 1`; must be ≤ 8.
- `clock`  in  1  system clock; all state changes on its rising edge.
- `reset`  in  1  reset, synchronous and active-high.
- `req`  in  NUM_REQ  per-slot gap request; a slot holds it high until its grant handshake completes.
- `rng_enable`  out  1  enable to the random generator.
- `rng_value`  in  8  current generator output.
- `gnt_valid`  out  1  grant offer valid.
- `gnt_ready`  in  1  consumer accepts the grant.
- `gnt_id`  out  clog2(NUM_REQ)  index of the granted slot.
- `gnt_gap`  out  9  granted gap top row.

## Operation
- States:
  - IDLE: `rng_enable` = 0. If `req` ≠ 0, latch the winner into `gnt_id` and go to SPIN.
  - SPIN: `rng_enable` = 1. The spin counter counts 0..`RNG_SETTLE`-1. Exit to CAPTURE when the counter reaches `RNG_SETTLE`-1.
  - CAPTURE: `rng_enable` = 0. Compute `cand` = `GAP_MIN` + `rng_value[GAP_SPAN_LOG2-1:0]` (zero-extended to 9 bits).
    - If `cand` == `last_gap` and `retry` = 0: set `retry`, clear the spin counter, go back to SPIN.
    - Otherwise: `gnt_gap` ← `cand`, go to OFFER.
  - OFFER: `gnt_valid` = 1. Hold `gnt_id` and `gnt_gap` stable until `gnt_ready` = 1.
    - On handshake: `last_gap` ← `gnt_gap`, `ptr` ← (`gnt_id` + 1) mod `NUM_REQ`, clear `retry`, go to IDLE.
- Arbitration: round-robin. The winner is the first set bit of `req`, searching from `ptr` upward with wrap-around.
- A winner latched in IDLE is committed. Deassertion of its `req` during SPIN, CAPTURE or OFFER does not abort the grant.
- At most one retry per grant. A second consecutive duplicate is issued as-is.
- `req` is ignored outside IDLE. A slot that lost arbitration keeps its request pending.

## Timing
- Reset values:
  - `rng_enable` = 0, `gnt_valid` = 0, `gnt_id` = 0, `gnt_gap` = 0.
  - `last_gap` = 0, `ptr` = 0, `retry` = 0, spin counter = 0, state = IDLE.
- Reset asserted in any state returns to IDLE on that edge and drops `rng_enable` and `gnt_valid` the following cycle. The generator is not reset by this block.
- Latency, with `req` high before edge E0 in IDLE:
  - `rng_enable` is high for exactly `RNG_SETTLE` cycles, E0..E0+`RNG_SETTLE`.
  - CAPTURE occupies the cycle after that.
  - `gnt_valid` rises after edge E0+`RNG_SETTLE`+1, i.e. 10 cycles with defaults.
  - A retry adds `RNG_SETTLE`+1 cycles.
- `gnt_ready` high on the first OFFER cycle completes the handshake in one cycle. IDLE is then re-entered, so back-to-back grants are spaced by at least one IDLE cycle.
- `gnt_ready` outside OFFER has no effect.
- `rng_value` is sampled only in CAPTURE.

## Test plan
- Reset, then single request: `req`=0001, generator returns 200 → `rng_enable` high 9 cycles, `gnt_valid` after 10 cycles, `gnt_id`=0, `gnt_gap`=40+72=112.
- Round-robin: hold `req`=1111 with `gnt_ready`=1 → grants to ids 0,1,2,3,0 in order. With `req`=1010 after a grant to id 1 → next grant goes to id 3, then id 1.
- Duplicate retry: two grants where the generator yields 200 then 72 (both map to 112) → second grant re-spins 9 extra cycles. A third identical value is issued as 112.
- Backpressure: `gnt_ready` held low 5 cycles in OFFER → `gnt_valid`, `gnt_id`, `gnt_gap` stable throughout, `rng_enable` stays 0, handshake on cycle 6.
- Request withdrawn mid-SPIN: winner drops `req` at SPIN cycle 4 → grant still offered with the same `gnt_id`.
- Reset mid-SPIN at cycle 5 → next cycle `rng_enable`=0, `gnt_valid`=0, `ptr`=0. A subsequent `req`=0100 is granted to id 2 after 10 cycles.
